// File: rtl/axi_sram_responder.sv
// Single-beat AXI3 slave backed by a word-addressed SRAM array.
// Independent read (fixed latency) and write (AW/W join) engines.
module axi_sram_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        arid_i,
  input  logic [31:0]       araddr_i,
  input  logic [7:0]        arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic [1:0]        arlock_i,
  input  logic [3:0]        arcache_i,
  input  logic [2:0]        arprot_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [3:0]        rid_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic [3:0]        awid_i,
  input  logic [31:0]       awaddr_i,
  input  logic [7:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic [1:0]        awlock_i,
  input  logic [3:0]        awcache_i,
  input  logic [2:0]        awprot_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [3:0]        wid_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [3:0]        bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic {WIdle, WResp} w_state_e;

  logic [31:0] mem_q [Depth];

  r_state_e          r_state_q, r_state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        ar_id_q, ar_id_d;
  logic [ADDR_W-1:0] ar_idx_q, ar_idx_d;
  logic [3:0]        rid_q, rid_d;
  logic [31:0]       rdata_q, rdata_d;

  w_state_e          w_state_q, w_state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [3:0]        awid_q, awid_d;
  logic [ADDR_W-1:0] aw_idx_q, aw_idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [3:0]        bid_q, bid_d;

  logic ar_hs, aw_hs, w_hs, commit;

  // Ignored AXI fields; the name keeps them out of unused-signal reports.
  logic unused_fields;
  assign unused_fields = ^{araddr_i[31:ADDR_W+2], araddr_i[1:0], arlen_i, arsize_i, arburst_i,
                           arlock_i, arcache_i, arprot_i, awaddr_i[31:ADDR_W+2], awaddr_i[1:0],
                           awlen_i, awsize_i, awburst_i, awlock_i, awcache_i, awprot_i, wid_i,
                           wlast_i};

  assign arready_o = (r_state_q == RIdle) && !reset_i;
  assign awready_o = (w_state_q == WIdle) && !aw_got_q && !reset_i;
  assign wready_o  = (w_state_q == WIdle) && !w_got_q && !reset_i;
  assign ar_hs     = arvalid_i && arready_o;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign commit    = (w_state_q == WIdle) && aw_got_q && w_got_q;

  assign rvalid_o = (r_state_q == RResp);
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = 2'b00;
  assign rlast_o  = 1'b1;
  assign bvalid_o = (w_state_q == WResp);
  assign bid_o    = bid_q;
  assign bresp_o  = 2'b00;

  always_comb begin
    r_state_d = r_state_q;
    cnt_d     = cnt_q;
    ar_id_d   = ar_id_q;
    ar_idx_d  = ar_idx_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          ar_id_d  = arid_i;
          ar_idx_d = araddr_i[ADDR_W+1:2];
          cnt_d    = 4'(RD_LAT);
          if (RD_LAT == 0) begin
            r_state_d = RResp;
            rid_d     = arid_i;
            rdata_d   = mem_q[araddr_i[ADDR_W+1:2]];
          end else begin
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          r_state_d = RResp;
          rid_d     = ar_id_q;
          rdata_d   = mem_q[ar_idx_q];
        end
      end
      RResp: begin
        if (rready_i) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awid_d    = awid_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awid_d   = awid_i;
          aw_idx_d = awaddr_i[ADDR_W+1:2];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
        end
        if (commit) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bid_d     = awid_q;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (bready_i) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state_q <= RIdle;
      cnt_q     <= '0;
      ar_id_q   <= '0;
      ar_idx_q  <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      w_state_q <= WIdle;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awid_q    <= '0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      cnt_q     <= cnt_d;
      ar_id_q   <= ar_id_d;
      ar_idx_q  <= ar_idx_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awid_q    <= awid_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bid_q     <= bid_d;
    end
  end

  // Memory is never cleared; a same-cycle read capture sees the pre-commit word.
  always_ff @(posedge clk_i) begin
    if (commit && !reset_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
